stall_ctrl: RTL

- Central pipeline stall scheduler for the five-stage MIPS core.
- Merges three stall sources into the single `StallBus` consumed by the IF/ID/EX/MEM/WB pipeline registers and the PC:
  - load-use hazard detected at ID;
  - multi-cycle divider occupancy at EX;
  - data-SRAM wait at MEM.
- Sequences the divider: owns its busy/done FSM and cycle counter.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/stall_ctrl_pkg.sv | 38 +++
 rtl/stall_ctrl_div_seq.sv | 74 +++++++
 rtl/stall_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared stall-bus encodings, stage bit map and divider FSM states
// for the five-stage core's stall scheduler.
package stall_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int PC_BIT  = 0;
    localparam int IF_BIT  = 1;
    localparam int ID_BIT  = 2;
    localparam int EX_BIT  = 3;
    localparam int MEM_BIT = 4;
    localparam int WB_BIT  = 5;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE    = 6'b000000;
    localparam stall_bus_t STALL_LOADUSE = 6'b000111;
    localparam stall_bus_t STALL_DIV     = 6'b001111;
    localparam stall_bus_t STALL_MEM     = 6'b011111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic reg_hit(
        input logic       uses,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/stall_ctrl_div_seq.sv
// Divider sequencer: IDLE/BUSY/DONE FSM with a busy-cycle down-counter.
// DONE is held while MEM stalls so EX cannot miss the result.
module div_seq
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic busy,
    output logic done,
    output logic starting
);

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_e      state_q;
    div_state_e      state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy     = 1'b0;
        done     = 1'b0;
        starting = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d  = DIV_BUSY;
                    count_d  = CW'(DIV_CYCLES - 1);
                    starting = 1'b1;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (count_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DIV_DONE: begin
                done = 1'b1;
                if (!hold) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        // A reset cycle masks status so an aborted divide never shows done.
        if (!rst) begin
            busy     = 1'b0;
            done     = 1'b0;
            starting = 1'b0;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Central stall scheduler: load-use detect, divider sequencing,
// MEM wait, priority-encoded stall bus and stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int STALL_W    = 6,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic [4:0]         ex_waddr,
    input  logic               div_start,
    input  logic               mem_stallreq,
    output logic [STALL_W-1:0] stall,
    output logic               div_busy,
    output logic               div_done,
    output logic               load_use,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic             hit_rs;
    logic             hit_rt;
    logic             div_starting;
    stall_bus_t       code;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit_rs = reg_hit(id_uses_rs, id_rs, ex_waddr);
    assign hit_rt = reg_hit(id_uses_rt, id_rt, ex_waddr);

    // Writes to $zero never create a dependency.
    assign load_use = ex_valid & ex_is_load &
                      (ex_waddr != 5'd0) & (hit_rs | hit_rt);

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .hold     (mem_stallreq),
        .busy     (div_busy),
        .done     (div_done),
        .starting (div_starting)
    );

    always_comb begin
        code = STALL_NONE;
        if (!rst) begin
            code = STALL_NONE;
        end else if (mem_stallreq) begin
            code = STALL_MEM;
        end else if (div_starting || div_busy) begin
            code = STALL_DIV;
        end else if (load_use) begin
            code = STALL_LOADUSE;
        end
    end

    assign stall = STALL_W'(code);

    always_comb begin
        cnt_d = cnt_q;
        if (code[PC_BIT] == STOP && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule
